// File: rtl/rf_wb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : rf_wb_pkg                                            |
// | Purpose  : Shared types and constants for the register-file     |
// |            write-back queue                                     |
// | Revision : 1.0 - initial release                                |
// +-----------------------------------------------------------------+
package rf_wb_pkg;

  localparam int RF_AW         = 4;
  localparam int RF_DW         = 16;
  localparam int DEFAULT_DEPTH = 4;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MDR = 1'b1;

  // One pending register-file write: source port, address field select,
  // destination register and the data to store.
  typedef struct packed {
    logic             src;
    logic             dstsel;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : rf_wb_fifo                                           |
// | Purpose  : Circular FIFO with ordered dual push, single pop and |
// |            a flat view of all occupied slots                    |
// | Revision : 1.0 - initial release                                |
// +-----------------------------------------------------------------+
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0_en,
  input  wb_entry_t                 push0_data,
  input  logic                      push1_en,
  input  wb_entry_t                 push1_data,
  input  logic                      pop_en,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          entry_valid,
  output wb_entry_t [DEPTH-1:0]     entries
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic [PW-1:0]         push1_slot;

  // Push0 lands at the tail, push1 right behind it; pointers wrap for free
  // because DEPTH is a power of two.
  always_comb begin
    mem_d      = mem_q;
    push1_slot = wr_ptr_q + PW'(push0_en);
    if (push0_en) mem_d[wr_ptr_q]   = push0_data;
    if (push1_en) mem_d[push1_slot] = push1_data;
    wr_ptr_d = wr_ptr_q + PW'(push0_en) + PW'(push1_en);
    rd_ptr_d = rd_ptr_q + PW'(pop_en);
    count_d  = count_q + (PW+1)'(push0_en) + (PW+1)'(push1_en) - (PW+1)'(pop_en);
  end

  // State register; reset empties the queue and discards pending writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A slot is occupied when its distance from the head is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_q;
    assign entry_valid[gi] = {1'b0, offset} < count_q;
  end

  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = mem_q;

endmodule
`default_nettype wire

// File: rtl/rf_writeback_queue.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | Module   : rf_writeback_queue                                   |
// | Purpose  : Buffers ALU / load results and issues one register-  |
// |            file write per cycle; reports pending-write hazards  |
// | Revision : 1.0 - initial release                                |
// +-----------------------------------------------------------------+
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [RF_AW-1:0] alu_addr,
  input  logic             alu_dstsel,
  input  logic [RF_DW-1:0] alu_data,
  input  logic             mdr_valid,
  output logic             mdr_ready,
  input  logic [RF_AW-1:0] mdr_addr,
  input  logic             mdr_dstsel,
  input  logic [RF_DW-1:0] mdr_data,
  input  logic             rf_hold,
  output logic             wb_regwrite,
  output logic             wb_regdst,
  output logic             wb_memtoreg,
  output logic [RF_AW-1:0] wb_addr_rt,
  output logic [RF_AW-1:0] wb_addr_swlw,
  output logic [RF_DW-1:0] wb_alu_data,
  output logic [RF_DW-1:0] wb_mdr_data,
  input  logic [RF_AW-1:0] q_addr1,
  input  logic [RF_AW-1:0] q_addr2,
  output logic             q_busy1,
  output logic             q_busy2
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ROOM1_LIM = CW'(DEPTH);
  localparam logic [CW-1:0] ROOM2_LIM = CW'(DEPTH - 1);

  logic [CW-1:0]         count;
  wb_entry_t             head;
  logic [DEPTH-1:0]      entry_valid;
  wb_entry_t [DEPTH-1:0] entries;
  wb_entry_t             mdr_entry, alu_entry;
  logic                  mdr_push, alu_push, pop;
  logic                  iss_valid_q, iss_valid_d;
  wb_entry_t             iss_entry_q, iss_entry_d;

  // Space is judged from the registered count only; when both ports offer,
  // the ALU needs a second free slot because MDR is enqueued first.
  assign mdr_ready = rst & (count < ROOM1_LIM);
  assign alu_ready = rst & (mdr_valid ? (count < ROOM2_LIM) : (count < ROOM1_LIM));

  // r0 is hardwired zero: accept such writes but never queue them.
  assign mdr_push = mdr_valid & mdr_ready & (mdr_addr != '0);
  assign alu_push = alu_valid & alu_ready & (alu_addr != '0);
  assign pop      = (count != '0) & ~rf_hold;

  assign mdr_entry = '{src: SRC_MDR, dstsel: mdr_dstsel, addr: mdr_addr, data: mdr_data};
  assign alu_entry = '{src: SRC_ALU, dstsel: alu_dstsel, addr: alu_addr, data: alu_data};

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0_en    (mdr_push),
    .push0_data  (mdr_entry),
    .push1_en    (alu_push),
    .push1_data  (alu_entry),
    .pop_en      (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  // Issue register loads the head when the file can take a write, else idles.
  always_comb begin
    iss_valid_d = pop;
    iss_entry_d = pop ? head : '0;
  end

  // Issue register state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iss_valid_q <= 1'b0;
      iss_entry_q <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_entry_q <= iss_entry_d;
    end
  end

  // Demux the issued entry onto the file's address/data inputs; unused ones read 0.
  always_comb begin
    wb_regwrite  = iss_valid_q;
    wb_regdst    = iss_valid_q & iss_entry_q.dstsel;
    wb_memtoreg  = iss_valid_q & iss_entry_q.src;
    wb_addr_rt   = '0;
    wb_addr_swlw = '0;
    wb_alu_data  = '0;
    wb_mdr_data  = '0;
    if (iss_valid_q) begin
      if (iss_entry_q.dstsel) wb_addr_rt   = iss_entry_q.addr;
      else                    wb_addr_swlw = iss_entry_q.addr;
      if (iss_entry_q.src)    wb_mdr_data  = iss_entry_q.data;
      else                    wb_alu_data  = iss_entry_q.data;
    end
  end

  // Hazard lookup: any queued or in-flight write to a nonzero read address.
  always_comb begin
    q_busy1 = iss_valid_q & (iss_entry_q.addr == q_addr1);
    q_busy2 = iss_valid_q & (iss_entry_q.addr == q_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entries[i].addr == q_addr1)) q_busy1 = 1'b1;
      if (entry_valid[i] && (entries[i].addr == q_addr2)) q_busy2 = 1'b1;
    end
    if (q_addr1 == '0) q_busy1 = 1'b0;
    if (q_addr2 == '0) q_busy2 = 1'b0;
  end

endmodule
`default_nettype wire

// File: doc/rf_writeback_queue.md
# rf_writeback_queue

Write-back initiator for the 16-entry x 16-bit register file. Accepts results from the ALU and from the memory data register (loads) over valid/ready handshakes. Buffers them in a 4-entry in-order queue and issues at most one register-file write per cycle, driving the file's write-control and write-data inputs. Also reports per-register pending-write status so decode can stall on read-after-write hazards.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted when valid&ready at edge
- alu_addr  in  4  destination register
- alu_dstsel  in  1  1 = RT/BT address field, 0 = SW/LW field
- alu_data  in  16  result
- mdr_valid, mdr_ready, mdr_addr, mdr_dstsel, mdr_data: same as ALU port, load data
- rf_hold  in  1  register file cannot accept a write this cycle
- wb_regwrite  out  1  drives C_RegWrite
- wb_regdst  out  1  drives C_RegDstWrite
- wb_memtoreg  out  1  drives C_MemToReg
- wb_addr_rt  out  4  drives A_WriteRegRT_BT when wb_regdst=1, else 0
- wb_addr_swlw  out  4  drives A_RegSWLW when wb_regdst=0, else 0
- wb_alu_data  out  16  drives D_ALU_IN when wb_memtoreg=0, else 0
- wb_mdr_data  out  16  drives D_MDR_IN when wb_memtoreg=1, else 0
- q_addr1, q_addr2  in  4  decode read addresses
- q_busy1, q_busy2  out  1  pending write to that address

## Operation
- Entry = {src (1=MDR), dstsel, addr[3:0], data[15:0]}, 22 bits.
- free = DEPTH − count. mdr_ready = rst & (free≥1). alu_ready = rst & (free≥2 if mdr_valid else free≥1). Both combinational from the registered count only; a same-cycle pop does not add space.
- Both ports accepted in one cycle: MDR entry enqueued first, ALU entry second.
- Accepted write with addr=0: handshake completes, entry discarded (r0 is hardwired zero); not counted, never issued.
- Issue register: each edge with rst=1 — if rf_hold=0 and queue non-empty, pop head into issue register (wb_regwrite=1). Otherwise issue register goes idle (all wb_* outputs 0). Writes are never repeated and never lost under hold.
- q_busyN = 1 iff q_addrN≠0 and q_addrN matches the addr of any valid queue entry or of the valid issue register. Combinational.
- Order preserved: entries issue strictly in enqueue order; two writes to one register both issue, later wins in the file.

## Timing
- Reset (rst=0 at edge): count=0, queue empty, issue register idle. All wb_* = 0, ready outputs 0, busy outputs 0. Handshakes during reset cycles are ignored. Reset mid-queue discards all pending writes.
- Latency: entry accepted at edge N → earliest wb_regwrite=1 in cycle after edge N+1; the file commits it at edge N+2.
- Throughput: one write per cycle sustained; up to two enqueues per cycle.
- Full (count=DEPTH): both readys 0. Simultaneous pop at that edge does not enable acceptance in the same cycle.
- Empty with rf_hold=0: issue register idle, no write.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits and never exceeds DEPTH.

## Structure
- Package rf_wb_pkg: entry struct, SRC_ALU/SRC_MDR constants, RF_AW=4, RF_DW=16, default DEPTH.
- Sub-module rf_wb_fifo: synchronous circular FIFO with dual push (ordered), single pop, count, and a flat view of valid entries for the busy comparators.
- Top holds handshake logic, r0 filter, issue register and output demux.

## Test plan
- Reset: rst=0 for 2 cycles with alu_valid=1 → all outputs 0, nothing issued after release; alu_ready=1 on first cycle after release.
- Single ALU write: addr=5, dstsel=1, data=0x1234 accepted at edge N → cycle after N+1: wb_regwrite=1, wb_regdst=1, wb_addr_rt=5, wb_alu_data=0x1234, wb_memtoreg=0; q_busy1 for addr 5 high from N to N+2.
- Dual enqueue: MDR (addr 3, 0xBEEF) and ALU (addr 3, 0x0001) same edge → MDR write issues first, then ALU; register 3 ends 0x0001.
- Full queue: fill 4 entries with rf_hold=1 → both readys 0; drop rf_hold → one write per cycle, readys return after first pop edge.
- r0 write: ALU addr 0, data 0xFFFF → handshake completes, no wb_regwrite, q_busy for addr 0 stays 0.
- Hold mid-stream: rf_hold=1 for 3 cycles during drain → no writes issue, no entry lost or duplicated, order intact.
